// File: rtl/u109_pci_target.sv
// U109 PCI target: claims PCI memory cycles into Amiga space, buffers one 4-longword line,
// posts writes and completes reads as delayed transactions through the 040 sequencer req/done port.
module u109_pci_target #(
  parameter int DISCARD_CLKS = 1024
) (
  input  logic        PCICLK,
  input  logic        nRESET,
  input  logic        nFRAME,
  input  logic        nIRDY,
  input  logic [31:0] AD_IN,
  input  logic [3:0]  CBE,
  input  logic        HIT,
  output logic [31:0] AD_OUT,
  output logic        AD_OE,
  output logic        nDEVSEL,
  output logic        nTRDY,
  output logic        nSTOP,
  output logic        TGT_OE,
  output logic        LREQ,
  output logic        LRNW,
  output logic [29:0] LADDR,
  output logic [2:0]  LCNT,
  input  logic [1:0]  LIDX,
  output logic [31:0] LWDATA,
  output logic [3:0]  LBE,
  input  logic [31:0] LRDATA,
  input  logic        LRWE,
  input  logic        LDONE,
  output logic [4:0]  dbg_state
);
  localparam int CW = $clog2(DISCARD_CLKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLAIM, S_WDATA, S_RDATA, S_RETRY, S_TURN} bus_state_t;
  typedef enum logic [1:0] {L_IDLE, L_POST, L_PEND} loc_state_t;

  bus_state_t state, state_n, dstate, data_nxt;
  loc_state_t lstate;

  logic          frame_q, cyc_wr, cyc_retry, cyc_hit, unal, rd_go;
  logic [1:0]    idx;
  logic [2:0]    wcnt;
  logic [29:0]   start_addr, entry_addr;
  logic          entry_valid;
  logic [CW-1:0] disc_cnt;
  logic [31:0]   line_q [4];
  logic [3:0]    be_q [4];

  logic addr_phase, is_rd, is_wr, claim, rd_match, rd_hit, rd_fetch, wr_accept, retry_now;
  logic stop_now, data_ph, xfer, hold_entry, stop_n;

  // Handshake: PCI side moves one word on every clock with IRDY# and TRDY# both low;
  // local side holds LREQ from launch until the single-clock LDONE pulse, never stalling the bus.
  assign addr_phase = (state == S_IDLE) && !nFRAME && frame_q;
  assign is_rd      = (CBE == 4'b0110);
  assign is_wr      = (CBE == 4'b0111);
  assign claim      = addr_phase && HIT && (is_rd || is_wr);
  assign rd_match   = entry_valid && (entry_addr == AD_IN[31:2]);
  assign rd_hit     = is_rd && (lstate == L_IDLE) && rd_match;
  assign rd_fetch   = is_rd && (lstate == L_IDLE) && !rd_match;
  assign wr_accept  = is_wr && (lstate == L_IDLE);
  assign retry_now  = (is_wr && !wr_accept) || (is_rd && !rd_hit);
  assign stop_now   = unal || (idx == 2'd3);
  assign data_ph    = (state == S_CLAIM && cyc_wr && !cyc_retry) || (state == S_WDATA) ||
                      (state == S_RDATA && rd_go);
  assign xfer       = data_ph && !nIRDY;
  assign stop_n     = !(stop_now && !nFRAME);
  // A served read entry must not age out while its burst is still in flight.
  assign hold_entry = (claim && rd_hit) || (cyc_hit && state != S_IDLE);

  assign LREQ      = (lstate != L_IDLE);
  assign LWDATA    = line_q[LIDX];
  assign LBE       = be_q[LIDX];
  assign dbg_state = {lstate, state};

  always_comb begin
    state_n  = state;
    nDEVSEL  = 1'b1;
    nTRDY    = 1'b1;
    nSTOP    = 1'b1;
    TGT_OE   = 1'b0;
    AD_OE    = 1'b0;
    dstate   = cyc_wr ? S_WDATA : S_RDATA;
    if (xfer)
      data_nxt = nFRAME ? S_TURN : (stop_now ? S_RETRY : dstate);
    else
      data_nxt = (nFRAME && nIRDY) ? S_TURN : dstate;
    case (state)
      S_IDLE: if (claim) state_n = S_CLAIM;
      S_CLAIM: begin
        nDEVSEL = 1'b0;
        TGT_OE  = 1'b1;
        if (cyc_retry) begin
          nSTOP   = 1'b0;
          state_n = S_RETRY;
        end else if (!cyc_wr) begin
          state_n = S_RDATA;
        end else begin
          nTRDY   = 1'b0;
          nSTOP   = stop_n;
          state_n = data_nxt;
        end
      end
      S_WDATA: begin
        nDEVSEL = 1'b0;
        TGT_OE  = 1'b1;
        nTRDY   = 1'b0;
        nSTOP   = stop_n;
        state_n = data_nxt;
      end
      S_RDATA: begin
        // First RDATA clock is the AD turnaround: drive AD but hold TRDY# off.
        nDEVSEL = 1'b0;
        TGT_OE  = 1'b1;
        AD_OE   = 1'b1;
        if (rd_go) begin
          nTRDY = 1'b0;
          nSTOP = stop_n;
        end
        state_n = data_nxt;
      end
      S_RETRY: begin
        nDEVSEL = 1'b0;
        TGT_OE  = 1'b1;
        nSTOP   = 1'b0;
        if (nFRAME) state_n = S_TURN;
      end
      S_TURN: begin
        TGT_OE  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    AD_OUT = AD_OE ? line_q[idx] : 32'h0;
  end

  always_ff @(posedge PCICLK or negedge nRESET) begin
    if (!nRESET) begin
      state      <= S_IDLE;
      frame_q    <= 1'b1;
      idx        <= 2'd0;
      wcnt       <= 3'd0;
      cyc_wr     <= 1'b0;
      cyc_retry  <= 1'b0;
      cyc_hit    <= 1'b0;
      unal       <= 1'b0;
      rd_go      <= 1'b0;
      start_addr <= 30'd0;
      for (int i = 0; i < 4; i++) begin
        line_q[i] <= 32'h0;
        be_q[i]   <= 4'h0;
      end
    end else begin
      state   <= state_n;
      frame_q <= nFRAME;
      if (claim) begin
        idx        <= AD_IN[3:2];
        unal       <= |AD_IN[1:0];
        start_addr <= AD_IN[31:2];
        cyc_wr     <= is_wr;
        cyc_retry  <= retry_now;
        cyc_hit    <= rd_hit;
        wcnt       <= 3'd0;
        rd_go      <= 1'b0;
        if (wr_accept)
          for (int i = 0; i < 4; i++) be_q[i] <= 4'h0;
      end else begin
        if (xfer) begin
          idx <= idx + 2'd1;
          if (cyc_wr) begin
            line_q[idx] <= AD_IN;
            be_q[idx]   <= ~CBE;
            wcnt        <= wcnt + 3'd1;
          end
        end
        if (state == S_RDATA) rd_go <= 1'b1;
      end
      if (LRWE && lstate == L_PEND) line_q[LIDX] <= LRDATA;
    end
  end

  // One line buffer serves both directions, so any accepted write kills the read entry.
  always_ff @(posedge PCICLK or negedge nRESET) begin
    if (!nRESET) begin
      lstate      <= L_IDLE;
      LRNW        <= 1'b1;
      LADDR       <= 30'd0;
      LCNT        <= 3'd0;
      entry_valid <= 1'b0;
      entry_addr  <= 30'd0;
      disc_cnt    <= '0;
    end else begin
      case (lstate)
        L_IDLE: begin
          if (claim && rd_fetch) begin
            lstate <= L_PEND;
            LRNW   <= 1'b1;
            LADDR  <= AD_IN[31:2];
            LCNT   <= 3'd4 - {1'b0, AD_IN[3:2]};
          end else if (state == S_TURN && cyc_wr && wcnt != 3'd0) begin
            lstate <= L_POST;
            LRNW   <= 1'b0;
            LADDR  <= start_addr;
            LCNT   <= wcnt;
          end
        end
        L_POST: if (LDONE) lstate <= L_IDLE;
        L_PEND: begin
          if (LDONE) begin
            lstate      <= L_IDLE;
            entry_valid <= 1'b1;
            disc_cnt    <= CW'(DISCARD_CLKS);
          end
        end
        default: lstate <= L_IDLE;
      endcase
      if (entry_valid && !hold_entry) begin
        disc_cnt <= disc_cnt - CW'(1);
        if (disc_cnt == CW'(1)) entry_valid <= 1'b0;
      end
      if (claim && rd_fetch) begin
        entry_addr  <= AD_IN[31:2];
        entry_valid <= 1'b0;
      end
      if (claim && wr_accept) entry_valid <= 1'b0;
      if (state == S_TURN && cyc_hit) entry_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_u109_pci_target.sv
// Directed bench for u109_pci_target: posted writes, delayed reads, retry, discard, decode and reset.
module tb_u109_pci_target;
  localparam int DISC = 8;

  logic        PCICLK = 1'b0;
  logic        nRESET, nFRAME, nIRDY, HIT, LRWE, LDONE;
  logic [31:0] AD_IN, LRDATA;
  logic [3:0]  CBE;
  logic [1:0]  LIDX;
  logic [31:0] AD_OUT, LWDATA;
  logic        AD_OE, nDEVSEL, nTRDY, nSTOP, TGT_OE, LREQ, LRNW;
  logic [29:0] LADDR;
  logic [2:0]  LCNT;
  logic [3:0]  LBE;
  logic [4:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wd [4];
  logic [31:0] fill [4];

  u109_pci_target #(.DISCARD_CLKS(DISC)) dut (
    .PCICLK(PCICLK), .nRESET(nRESET), .nFRAME(nFRAME), .nIRDY(nIRDY), .AD_IN(AD_IN),
    .CBE(CBE), .HIT(HIT), .AD_OUT(AD_OUT), .AD_OE(AD_OE), .nDEVSEL(nDEVSEL), .nTRDY(nTRDY),
    .nSTOP(nSTOP), .TGT_OE(TGT_OE), .LREQ(LREQ), .LRNW(LRNW), .LADDR(LADDR), .LCNT(LCNT),
    .LIDX(LIDX), .LWDATA(LWDATA), .LBE(LBE), .LRDATA(LRDATA), .LRWE(LRWE), .LDONE(LDONE),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 PCICLK = ~PCICLK;

  // Target pins packed as {nDEVSEL, nTRDY, nSTOP, TGT_OE, AD_OE}
  localparam logic [4:0] P_REL   = 5'b11100;
  localparam logic [4:0] P_TURN  = 5'b11110;
  localparam logic [4:0] P_RETRY = 5'b01010;
  localparam logic [4:0] P_WXFER = 5'b00110;
  localparam logic [4:0] P_WDISC = 5'b00010;
  localparam logic [4:0] P_RCLM  = 5'b01110;
  localparam logic [4:0] P_RTAR  = 5'b01111;
  localparam logic [4:0] P_RXFER = 5'b00111;
  localparam logic [4:0] P_RDISC = 5'b00011;

  function automatic logic [4:0] tgt();
    return {nDEVSEL, nTRDY, nSTOP, TGT_OE, AD_OE};
  endfunction

  // Driver tasks: inputs change 2 time units after the edge, checks 1 unit later
  task automatic tick();
    @(posedge PCICLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic bus_idle();
    nFRAME = 1'b1; nIRDY = 1'b1; AD_IN = 32'h0; CBE = 4'hF; HIT = 1'b0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd, input logic h);
    nFRAME = 1'b0; nIRDY = 1'b1; AD_IN = a; CBE = cmd; HIT = h;
  endtask

  task automatic ldone_pulse();
    LDONE = 1'b1;
    tick();
    LDONE = 1'b0;
  endtask

  // Scoreboard compare
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    wd   = '{32'hAAAA0000, 32'hBBBB1111, 32'hCCCC2222, 32'hDDDD3333};
    fill = '{32'h0, 32'h11111111, 32'h22222222, 32'h33333333};
    nRESET = 1'b1;
    bus_idle();
    LIDX = 2'd0; LRDATA = 32'h0; LRWE = 1'b0; LDONE = 1'b0;
    #1 nRESET = 1'b0;
    settle();
    chk("rst pins", 32'(tgt()), 32'(P_REL));
    chk("rst ad_out", AD_OUT, 32'h0);
    chk("rst lreq", 32'(LREQ), 32'd0);
    chk("rst lrnw", 32'(LRNW), 32'd1);
    chk("rst laddr", 32'(LADDR), 32'd0);
    chk("rst lcnt", 32'(LCNT), 32'd0);
    repeat (2) tick();
    nRESET = 1'b1;
    tick();

    // Posted write, 4 words from 0x0800_0000
    addr_phase(32'h0800_0000, 4'b0111, 1'b1);
    settle();
    chk("w4 addr pins", 32'(tgt()), 32'(P_REL));
    tick();
    HIT = 1'b0; nIRDY = 1'b0; CBE = 4'h0;
    for (int i = 0; i < 4; i++) begin
      AD_IN = wd[i];
      nFRAME = (i == 3);
      settle();
      chk($sformatf("w4 data%0d pins", i), 32'(tgt()), 32'(P_WXFER));
      tick();
    end
    bus_idle();
    settle();
    chk("w4 turn", 32'(tgt()), 32'(P_TURN));
    tick();
    settle();
    chk("w4 released", 32'(tgt()), 32'(P_REL));
    chk("w4 lreq", 32'(LREQ), 32'd1);
    chk("w4 lrnw", 32'(LRNW), 32'd0);
    chk("w4 laddr", 32'(LADDR), 32'h0200_0000);
    chk("w4 lcnt", 32'(LCNT), 32'd4);
    for (int i = 0; i < 4; i++) begin
      LIDX = 2'(i);
      settle();
      chk($sformatf("w4 lwdata%0d", i), LWDATA, wd[i]);
      chk($sformatf("w4 lbe%0d", i), 32'(LBE), 32'hF);
    end
    ldone_pulse();
    settle();
    chk("w4 lreq drop", 32'(LREQ), 32'd0);

    // Write at 0x0800_0008 as a 4-beat burst: disconnect-A after 2 words
    tick();
    addr_phase(32'h0800_0008, 4'b0111, 1'b1);
    tick();
    HIT = 1'b0; nIRDY = 1'b0; CBE = 4'h0; AD_IN = 32'h1234_5678;
    settle();
    chk("w2 beat0 pins", 32'(tgt()), 32'(P_WXFER));
    tick();
    AD_IN = 32'h9ABC_DEF0;
    settle();
    chk("w2 beat1 disc-A", 32'(tgt()), 32'(P_WDISC));
    tick();
    AD_IN = 32'h5A5A_5A5A;
    settle();
    chk("w2 beat2 stopped", 32'(tgt()), 32'(P_RETRY));
    tick();
    nFRAME = 1'b1;
    settle();
    chk("w2 last stop", 32'(tgt()), 32'(P_RETRY));
    tick();
    bus_idle();
    settle();
    chk("w2 turn", 32'(tgt()), 32'(P_TURN));
    tick();
    settle();
    chk("w2 lreq", 32'(LREQ), 32'd1);
    chk("w2 laddr", 32'(LADDR), 32'h0200_0002);
    chk("w2 lcnt", 32'(LCNT), 32'd2);
    LIDX = 2'd3;
    settle();
    chk("w2 lwdata3", LWDATA, 32'h9ABC_DEF0);

    // Write while POST is outstanding: retried, buffer untouched
    addr_phase(32'h0800_0000, 4'b0111, 1'b1);
    tick();
    HIT = 1'b0; nFRAME = 1'b1; nIRDY = 1'b0; CBE = 4'h0; AD_IN = 32'hFFFF_FFFF;
    settle();
    chk("wpost retry", 32'(tgt()), 32'(P_RETRY));
    tick();
    nIRDY = 1'b1;
    settle();
    chk("wpost retry hold", 32'(tgt()), 32'(P_RETRY));
    tick();
    bus_idle();
    settle();
    chk("wpost turn", 32'(tgt()), 32'(P_TURN));
    tick();
    LIDX = 2'd2;
    settle();
    chk("wpost buf2", LWDATA, 32'h1234_5678);
    LIDX = 2'd0;
    settle();
    chk("wpost buf0", LWDATA, 32'hAAAA_0000);
    chk("wpost lcnt", 32'(LCNT), 32'd2);
    ldone_pulse();

    // Decode rejects: HIT=0, then I/O read command
    for (int k = 0; k < 2; k++) begin
      tick();
      addr_phase(32'h0800_0000, (k == 0) ? 4'b0111 : 4'b0010, (k == 0) ? 1'b0 : 1'b1);
      tick();
      HIT = 1'b0; nFRAME = 1'b1; nIRDY = 1'b0; CBE = 4'h0;
      for (int j = 0; j < 3; j++) begin
        settle();
        chk($sformatf("ignore%0d c%0d", k, j), 32'(tgt()), 32'(P_REL));
        tick();
        bus_idle();
      end
      chk($sformatf("ignore%0d lreq", k), 32'(LREQ), 32'd0);
    end

    // Delayed read of 0x0800_0004: retry + fetch of 3 longwords
    addr_phase(32'h0800_0004, 4'b0110, 1'b1);
    tick();
    HIT = 1'b0; nFRAME = 1'b1; nIRDY = 1'b0; CBE = 4'h0; AD_IN = 32'h0;
    settle();
    chk("rd miss retry", 32'(tgt()), 32'(P_RETRY));
    chk("rd miss lreq", 32'(LREQ), 32'd1);
    chk("rd miss lrnw", 32'(LRNW), 32'd1);
    chk("rd miss laddr", 32'(LADDR), 32'h0200_0001);
    chk("rd miss lcnt", 32'(LCNT), 32'd3);
    tick();
    nIRDY = 1'b1;
    tick();
    bus_idle();
    tick();
    for (int i = 1; i < 4; i++) begin
      LIDX = 2'(i); LRDATA = fill[i]; LRWE = 1'b1;
      tick();
    end
    LRWE = 1'b0;
    ldone_pulse();
    settle();
    chk("rd fill lreq drop", 32'(LREQ), 32'd0);

    // Initiator retries the read and gets the buffered line
    addr_phase(32'h0800_0004, 4'b0110, 1'b1);
    tick();
    HIT = 1'b0; nFRAME = 1'b0; nIRDY = 1'b0; CBE = 4'h0; AD_IN = 32'h0;
    settle();
    chk("rd hit claim", 32'(tgt()), 32'(P_RCLM));
    tick();
    settle();
    chk("rd hit turnaround", 32'(tgt()), 32'(P_RTAR));
    tick();
    exp_q.push_back(32'h1111_1111);
    exp_q.push_back(32'h2222_2222);
    exp_q.push_back(32'h3333_3333);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk($sformatf("rd beat%0d pins", i), 32'(tgt()), 32'((i == 2) ? P_RDISC : P_RXFER));
      chk($sformatf("rd beat%0d data", i), AD_OUT, exp_q.pop_front());
      tick();
    end
    settle();
    chk("rd after disc", 32'(tgt()), 32'(P_RETRY));
    nFRAME = 1'b1;
    tick();
    nIRDY = 1'b1;
    settle();
    chk("rd turn", 32'(tgt()), 32'(P_TURN));
    tick();
    bus_idle();
    tick();

    // Entry consumed at TURN: same address now refetches
    addr_phase(32'h0800_0004, 4'b0110, 1'b1);
    tick();
    HIT = 1'b0; nFRAME = 1'b1; nIRDY = 1'b0; CBE = 4'h0; AD_IN = 32'h0;
    settle();
    chk("reread retry", 32'(tgt()), 32'(P_RETRY));
    chk("reread lreq", 32'(LREQ), 32'd1);
    tick();
    nIRDY = 1'b1;
    tick();
    bus_idle();
    tick();
    ldone_pulse();

    // Entry left unclaimed past DISC clocks is discarded
    repeat (DISC + 4) tick();
    addr_phase(32'h0800_0004, 4'b0110, 1'b1);
    tick();
    HIT = 1'b0; nFRAME = 1'b1; nIRDY = 1'b0; CBE = 4'h0;
    settle();
    chk("discard retry", 32'(tgt()), 32'(P_RETRY));
    chk("discard new lreq", 32'(LREQ), 32'd1);
    chk("discard lcnt", 32'(LCNT), 32'd3);
    tick();
    nIRDY = 1'b1;
    tick();
    bus_idle();
    tick();
    ldone_pulse();
    tick();

    // Reset in the middle of a write burst
    addr_phase(32'h0800_0000, 4'b0111, 1'b1);
    tick();
    HIT = 1'b0; nIRDY = 1'b0; CBE = 4'h0; AD_IN = 32'h5555_5555;
    tick();
    AD_IN = 32'h6666_6666;
    settle();
    chk("rst mid wdata", 32'(tgt()), 32'(P_WXFER));
    nRESET = 1'b0;
    settle();
    chk("rst mid pins", 32'(tgt()), 32'(P_REL));
    chk("rst mid lreq", 32'(LREQ), 32'd0);
    chk("rst mid laddr", 32'(LADDR), 32'd0);
    chk("rst mid lcnt", 32'(LCNT), 32'd0);
    bus_idle();
    tick();
    nRESET = 1'b1;
    tick();

    // Single-word write after reset, partial byte enables
    addr_phase(32'h0800_0010, 4'b0111, 1'b1);
    tick();
    HIT = 1'b0; nFRAME = 1'b1; nIRDY = 1'b0; CBE = 4'b1100; AD_IN = 32'hCAFE_F00D;
    settle();
    chk("w1 pins", 32'(tgt()), 32'(P_WXFER));
    tick();
    bus_idle();
    settle();
    chk("w1 turn", 32'(tgt()), 32'(P_TURN));
    tick();
    LIDX = 2'd0;
    settle();
    chk("w1 lreq", 32'(LREQ), 32'd1);
    chk("w1 laddr", 32'(LADDR), 32'h0200_0004);
    chk("w1 lcnt", 32'(LCNT), 32'd1);
    chk("w1 lwdata", LWDATA, 32'hCAFE_F00D);
    chk("w1 lbe", 32'(LBE), 32'h3);
    ldone_pulse();
    settle();
    chk("w1 lreq drop", 32'(LREQ), 32'd0);

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
